// File: rtl/xc_sha256_msched.sv
// SHA-256 message-schedule expander.
// Accepts one 512-bit block as 16 words W0..W15 and emits W0..W63, one
// word per out_fire. A 16-entry sliding window holds the last 16 schedule
// words. Each expanded word overwrites the slot of W[t-16], which is no
// longer needed once W[t] has been emitted.
// Optional: define XC_SHA256_MSCHED_PERF_EN to add perf_stall, a saturating
// count of cycles with out_valid & !out_ready. Only g_reset clears it.
module xc_sha256_msched (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
`ifdef XC_SHA256_MSCHED_PERF_EN
  ,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [3:0]         lcnt;
  logic [5:0]         t;
  logic [15:0][31:0]  win;

  logic               in_fire, out_fire;
  logic [3:0]         tl, i2, i7, i15;
  logic [31:0]        sched;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign out_idx   = t;
  assign out_last  = out_valid && (t == 6'd63);
  assign busy      = !((state == LOAD) && (lcnt == 4'd0));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Window taps for W[t]. The slot indices wrap modulo 16.
  always_comb begin
    tl    = t[3:0];
    i2    = tl - 4'd2;
    i7    = tl - 4'd7;
    i15   = tl + 4'd1;
    sched = sig1(win[i2]) + win[i7] + sig0(win[i15]) + win[tl];
    out_data = 32'd0;
    if (state == EMIT)
      out_data = (t[5:4] == 2'b00) ? win[tl] : sched;
  end

  // State register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= LOAD;
    else         state <= state_nxt;
  end

  // Next state. flush overrides both handshakes.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: if (in_fire && lcnt == 4'd15)  state_nxt = EMIT;
        EMIT: if (out_fire && t == 6'd63)    state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Counters and window. The window is not cleared on flush.
  // lcnt wraps 15->0 on the last load. t wraps 63->0 on the last emit.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lcnt <= 4'd0;
      t    <= 6'd0;
      win  <= '0;
    end else if (flush) begin
      lcnt <= 4'd0;
      t    <= 6'd0;
    end else begin
      if (in_fire) begin
        win[lcnt] <= in_data;
        lcnt      <= lcnt + 4'd1;
      end
      if (out_fire) begin
        if (t[5:4] != 2'b00) win[tl] <= out_data;
        t <= t + 6'd1;
      end
    end
  end

`ifdef XC_SHA256_MSCHED_PERF_EN
  // Count downstream stall cycles. The count saturates at all ones.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)
      perf_stall <= 32'd0;
    else if (out_valid && !out_ready && perf_stall != 32'hFFFF_FFFF)
      perf_stall <= perf_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_xc_sha256_msched.sv
// Directed bench for xc_sha256_msched.
// Covers: the "abc" block, sigma1 isolation, backpressure, flush in LOAD and
// in EMIT, async reset during EMIT, and back-to-back blocks.
module tb_xc_sha256_msched;
  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
`ifdef XC_SHA256_MSCHED_PERF_EN
  logic [31:0] perf_stall;
`endif

  xc_sha256_msched dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
`ifdef XC_SHA256_MSCHED_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 g_clk = ~g_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          stalls = 0;
  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [31:0] inw [32];
  logic [31:0] exp2 [128];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0m(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1m(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule over a full 64-entry array.
  task automatic build_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = s1m(exp_w[i-2]) + exp_w[i-7] + s0m(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
  endtask

  // Call at a negedge. Returns at the negedge after the 16th in_fire.
  task automatic load_block();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      chk("load_in_ready", 32'(in_ready), 32'd1);
      @(negedge g_clk);
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("emit_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Emit words 0..upto-1. If bp is set, out_ready follows 1,0,0,1.
  // When upto < 64, returns with word upto presented but not fired.
  task automatic collect(input int upto, input logic bp);
    int got = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_d = 32'd0;
    logic [5:0]  prev_i = 6'd0;
    logic [3:0]  pat = 4'b1001;
    logic rdy;
    while (got < upto && cyc < 1000) begin
      rdy = bp ? pat[cyc % 4] : 1'b1;
      out_ready = rdy;
      chk("out_valid_held", 32'(out_valid), 32'd1);
      chk("out_idx", 32'(out_idx), 32'(got));
      chk("out_data", out_data, exp_w[got]);
      chk("out_last", 32'(out_last), 32'(got == 63));
      if (prev_stall) begin
        chk("stall_data_stable", out_data, prev_d);
        chk("stall_idx_stable", 32'(out_idx), 32'(prev_i));
      end
      prev_stall = !rdy;
      prev_d = out_data;
      prev_i = out_idx;
      if (!rdy) stalls++;
      else begin
        got_w[got] = out_data;
        got++;
      end
      @(negedge g_clk);
      cyc++;
    end
    if (got < upto) begin
      vectors++;
      miscompares++;
      $error("FAIL collect_timeout observed=%0d expected=%0d", got, upto);
    end
    if (upto == 64) begin
      chk("after_last_out_valid", 32'(out_valid), 32'd0);
      chk("after_last_in_ready", 32'(in_ready), 32'd1);
      chk("after_last_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef XC_SHA256_MSCHED_PERF_EN
    chk("rst_perf", perf_stall, 32'd0);
`endif
    #2 g_reset = 1'b0;
    @(negedge g_clk);

    // "abc" block at full rate.
    set_abc(); build_exp();
    load_block();
    collect(64, 1'b0);
    chk("abc_w0", got_w[0], 32'h6162_6380);
    chk("abc_w15", got_w[15], 32'h0000_0018);
    chk("abc_w16", got_w[16], 32'h6162_6380);
    chk("abc_w17", got_w[17], 32'h000F_0000);
    chk("abc_w18", got_w[18], 32'h7DA8_6405);
    chk("abc_w19", got_w[19], 32'h6000_03C6);

    // sigma1 isolation.
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[14] = 32'h0000_0001;
    build_exp();
    load_block();
    collect(64, 1'b0);
    chk("sig1_w16", got_w[16], 32'h0000_A000);

    // Backpressure with out_ready 1,0,0,1.
    set_abc(); build_exp();
    stalls = 0;
    load_block();
    collect(64, 1'b1);
    chk("bp_w17", got_w[17], 32'h000F_0000);
`ifdef XC_SHA256_MSCHED_PERF_EN
    chk("perf_stall", perf_stall, 32'(stalls));
`endif

    // Flush after 7 words. The flush cycle's in_fire must be dropped.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA5A5_0000 + 32'(i);
      @(negedge g_clk);
    end
    chk("mid_load_busy", 32'(busy), 32'd1);
    flush = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge g_clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_load_busy", 32'(busy), 32'd0);
    chk("flush_load_in_ready", 32'(in_ready), 32'd1);

    // Flush at t=30, with same-cycle out_fire and in_valid.
    for (int i = 0; i < 16; i++) blk[i] = 32'h1111_1111 * 32'(i + 1);
    build_exp();
    load_block();
    collect(30, 1'b0);
    chk("pre_flush_idx", 32'(out_idx), 32'd30);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge g_clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_emit_out_valid", 32'(out_valid), 32'd0);
    chk("flush_emit_idx", 32'(out_idx), 32'd0);
    chk("flush_emit_busy", 32'(busy), 32'd0);
    set_abc(); build_exp();
    load_block();
    collect(64, 1'b0);
    chk("post_flush_w16", got_w[16], 32'h6162_6380);

    // Async reset at t=40. It must take effect without a clock edge.
    for (int i = 0; i < 16; i++) blk[i] = 32'h0F0F_0000 ^ 32'(i * 77);
    build_exp();
    load_block();
    collect(40, 1'b0);
    out_ready = 1'b1;
    #1 g_reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
`ifdef XC_SHA256_MSCHED_PERF_EN
    chk("async_rst_perf", perf_stall, 32'd0);
`endif
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    set_abc(); build_exp();
    load_block();
    collect(64, 1'b0);
    chk("post_rst_w18", got_w[18], 32'h7DA8_6405);

    // Back-to-back: "abc", then a second block, with in_valid held high.
    set_abc(); build_exp();
    for (int i = 0; i < 16; i++) inw[i] = blk[i];
    for (int i = 0; i < 64; i++) exp2[i] = exp_w[i];
    for (int i = 0; i < 16; i++) blk[i] = 32'h8000_0000 | 32'(i * 32'h0101_0101);
    build_exp();
    for (int i = 0; i < 16; i++) inw[16 + i] = blk[i];
    for (int i = 0; i < 64; i++) exp2[64 + i] = exp_w[i];
    begin
      int in_ptr = 0;
      int out_cnt = 0;
      int last_cyc = -100;
      int first2_cyc = -1;
      int cyc = 0;
      out_ready = 1'b1;
      while (out_cnt < 128 && cyc < 400) begin
        in_valid = (in_ptr < 32);
        in_data  = (in_ptr < 32) ? inw[in_ptr] : 32'd0;
        if (in_valid && in_ready) begin
          if (in_ptr == 16) first2_cyc = cyc;
          in_ptr++;
        end
        if (out_valid) begin
          chk("b2b_data", out_data, exp2[out_cnt]);
          chk("b2b_idx", 32'(out_idx), 32'(out_cnt % 64));
          chk("b2b_last", 32'(out_last), 32'(out_cnt % 64 == 63));
          if (out_cnt == 63) last_cyc = cyc;
          out_cnt++;
        end
        @(negedge g_clk);
        cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_turnaround", 32'(first2_cyc - last_cyc), 32'd1);
      chk("b2b_total", 32'(out_cnt), 32'd128);
      chk("b2b_idle", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
